// File: rtl/load_store_unit_if.sv
// Request, response and BRAM_MMIO signals between the memory stage, the
// load/store sequencer and the memory block.
interface load_store_unit_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddress;
  logic [31:0] reqWriteData;
  logic        respValid;
  logic        respFault;
  logic [31:0] loadData;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;

  modport slave (
    input  reqValid, reqStore, reqFunct3, reqAddress, reqWriteData, memReadData,
    output reqReady, respValid, respFault, loadData, memAddress, memWriteData,
           memWrite, byteMask
  );

  modport master (
    output reqValid, reqStore, reqFunct3, reqAddress, reqWriteData, memReadData,
    input  reqReady, respValid, respFault, loadData, memAddress, memWriteData,
           memWrite, byteMask
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: takes one RV32I load or store at a time, rejects
// illegal, misaligned or out-of-range requests, drives BRAM_MMIO for one
// cycle and extends the returned lane for loads.
module load_store_unit #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_TOP  = 32'h0000_01ff
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] memAddress_q;
  logic [31:0] loadData_q, loadData_d;

  logic        acceptReq;
  logic        illegalFunct3, misaligned, belowBase, aboveTop, reqFault;
  logic [2:0]  accessBytes;
  logic [32:0] baseOffset, lastByte;

  assign acceptReq = (state_q == IDLE) && bus.reqValid && !reset;

  // Classify the incoming request; the 33-bit sums keep range checks free of wraparound.
  always_comb begin
    accessBytes = 3'd1;
    case (bus.reqFunct3[1:0])
      2'b01:   accessBytes = 3'd2;
      2'b10:   accessBytes = 3'd4;
      default: accessBytes = 3'd1;
    endcase
    if (bus.reqStore) begin
      illegalFunct3 = !((bus.reqFunct3 == 3'b000) || (bus.reqFunct3 == 3'b001) ||
                        (bus.reqFunct3 == 3'b010));
    end else begin
      illegalFunct3 = (bus.reqFunct3 == 3'b011) || (bus.reqFunct3 == 3'b110) ||
                      (bus.reqFunct3 == 3'b111);
    end
    misaligned = ((bus.reqFunct3[1:0] == 2'b01) && bus.reqAddress[0]) ||
                 ((bus.reqFunct3[1:0] == 2'b10) && (bus.reqAddress[1:0] != 2'b00));
    baseOffset = {1'b0, bus.reqAddress} - {1'b0, ADDR_BASE};
    belowBase  = baseOffset[32];
    lastByte   = {1'b0, bus.reqAddress} + {30'd0, accessBytes} - 33'd1;
    aboveTop   = lastByte > {1'b0, ADDR_TOP};
    reqFault   = illegalFunct3 || misaligned || belowBase || aboveTop;
  end

  // Pick the addressed lane out of the registered read data and extend it.
  always_comb begin
    loadData_d = bus.memReadData;
    case (funct3_q)
      3'b000:  loadData_d = {{24{bus.memReadData[8*offset_q+7]}}, bus.memReadData[8*offset_q +: 8]};
      3'b100:  loadData_d = {24'd0, bus.memReadData[8*offset_q +: 8]};
      3'b001:  loadData_d = offset_q[1] ? {{16{bus.memReadData[31]}}, bus.memReadData[31:16]}
                                        : {{16{bus.memReadData[15]}}, bus.memReadData[15:0]};
      3'b101:  loadData_d = offset_q[1] ? {16'd0, bus.memReadData[31:16]}
                                        : {16'd0, bus.memReadData[15:0]};
      default: loadData_d = bus.memReadData;
    endcase
  end

  // State register; reset always returns to IDLE and drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus all handshake and memory strobes; every strobe is masked while reset is high.
  always_comb begin
    state_d          = state_q;
    bus.reqReady     = 1'b0;
    bus.respValid    = 1'b0;
    bus.respFault    = 1'b0;
    bus.memWrite     = 1'b0;
    bus.byteMask     = 4'b0000;
    bus.memWriteData = 32'd0;
    case (state_q)
      IDLE: begin
        bus.reqReady = !reset;
        if (acceptReq) state_d = reqFault ? RESP : ISSUE;
      end
      ISSUE: begin
        state_d = store_q ? RESP : CAPTURE;
        if (store_q && !reset) begin
          bus.memWrite = 1'b1;
          case (funct3_q[1:0])
            2'b00: begin
              bus.byteMask     = 4'b0001 << offset_q;
              bus.memWriteData = {4{wdata_q[7:0]}};
            end
            2'b01: begin
              bus.byteMask     = offset_q[1] ? 4'b1100 : 4'b0011;
              bus.memWriteData = {2{wdata_q[15:0]}};
            end
            default: begin
              bus.byteMask     = 4'b1111;
              bus.memWriteData = wdata_q;
            end
          endcase
        end
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        state_d       = IDLE;
        bus.respValid = !reset;
        bus.respFault = fault_q && !reset;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request on acceptance and capture the extended load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q      <= 1'b0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
      wdata_q      <= 32'd0;
      fault_q      <= 1'b0;
      memAddress_q <= 32'd0;
      loadData_q   <= 32'd0;
    end else begin
      if (acceptReq) begin
        store_q  <= bus.reqStore;
        funct3_q <= bus.reqFunct3;
        offset_q <= bus.reqAddress[1:0];
        wdata_q  <= bus.reqWriteData;
        fault_q  <= reqFault;
        if (!reqFault) memAddress_q <= {bus.reqAddress[31:2], 2'b00};
      end
      if (state_q == CAPTURE) loadData_q <= loadData_d;
    end
  end

  assign bus.loadData   = loadData_q;
  assign bus.memAddress = memAddress_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the multicycle core's memory stage and the BRAM_MMIO block. Accepts one load or store request at a time, encoded with RV32I funct3, and generates the word address, byte-lane mask and lane-replicated write data that BRAM_MMIO consumes. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word from the registered read data. Misaligned, out-of-range and illegal-funct3 requests are rejected with a fault and never reach memory.

## Interface
- ADDR_BASE, 32'h0000_0000, lowest legal byte address
- ADDR_TOP, 32'h0000_01ff, highest legal byte address (inclusive)

- clk  in  1  core clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- reqValid  in  1  request present
- reqReady  out  1  unit idle; request accepted on an edge where reqValid && reqReady
- reqStore  in  1  1 = store, 0 = load
- reqFunct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- reqAddress  in  32  byte address
- reqWriteData  in  32  rs2 value, right-aligned
- respValid  out  1  one-cycle completion pulse
- respFault  out  1  valid with respValid; 1 = request rejected
- loadData  out  32  extended load result; held until the next load completes
- memAddress  out  32  word-aligned address to BRAM_MMIO
- memWriteData  out  32  lane-replicated store data
- memWrite  out  1  write strobe
- byteMask  out  4  byte-lane enables
- memReadData  in  32  BRAM_MMIO registered read data, valid one cycle after the address is presented

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: reqReady=1. On acceptance, the unit latches reqStore, reqFunct3, reqAddress[1:0] and reqWriteData, plus memAddress={reqAddress[31:2],2'b00}.
  - Legal request: go to ISSUE.
  - Faulting request: go to RESP with fault set. No memory access occurs and memAddress is not updated.
- Fault conditions:
  - Illegal funct3: loads with 011/110/111; stores with anything other than 000/001/010.
  - Misalignment: H access with addr[0]=1; W access with addr[1:0]!=0.
  - Range: byte address < ADDR_BASE, or last accessed byte > ADDR_TOP.
- ISSUE: drive the memory outputs for exactly one cycle. Next state is RESP for a store, CAPTURE for a load.
  - memWrite=reqStore.
  - Store byteMask: SB = 4'b0001<<addr[1:0]; SH = addr[1] ? 1100 : 0011; SW = 1111.
  - Load byteMask = 0000.
  - memWriteData: SB = {4{wd[7:0]}}; SH = {2{wd[15:0]}}; SW = wd.
- CAPTURE: memReadData is valid this cycle.
  - Select byte lane addr[1:0] or halfword lane addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
  - Register the result into loadData, then go to RESP.
- RESP: respValid=1, respFault as latched; go to IDLE. loadData is unchanged by stores and faults.
- memWrite=0 and byteMask=0000 in every state except ISSUE.
- memWrite is gated by !reset, so no write ever occurs on a reset edge.

## Timing
- Reset values: state IDLE; reqReady=0 while reset is high, 1 on the first cycle after; respValid=0, respFault=0, loadData=0, memAddress=0, memWriteData=0, memWrite=0, byteMask=0.
- Latency from the accept edge to the respValid cycle:
  - Store: 2 cycles (ISSUE, RESP).
  - Load: 3 cycles (ISSUE, CAPTURE, RESP).
  - Fault: 1 cycle (RESP).
- reqReady is low in ISSUE, CAPTURE and RESP. reqValid in those cycles is ignored, not queued.
- A new request may be accepted in the IDLE cycle that immediately follows RESP. Maximum throughput is one store per 3 cycles and one load per 4 cycles.
- Reset asserted in any state: the next state is IDLE, any in-flight response is dropped, and no respValid is produced.

## Test plan
- Reset, then SW 0xDEADBEEF at 0x0 → ISSUE drives memAddress=0, byteMask=1111, memWrite=1; respValid 2 cycles after accept. Then LW 0x0 → loadData=DEADBEEF 3 cycles after accept, respFault=0.
- SB 0x000000FF at 0x5 → byteMask=0010, memWriteData=FFFFFFFF. LB 0x5 → loadData=FFFFFFFF; LBU 0x5 → 000000FF.
- SH 0x8001 at 0xA → byteMask=1100, memWriteData=80018001. LH 0xA → FFFF8001; LHU 0xA → 00008001; LW 0x8 → upper half 8001.
- Faults:
  - LW 0x2 and SH 0x3 → respFault=1 one cycle after accept, memWrite never asserted.
  - SW 0x200 (beyond ADDR_TOP) → fault.
  - Load funct3=011 → fault.
  - In every case loadData is unchanged.
- Reset asserted during a store's ISSUE cycle → memWrite=0 on that cycle, no respValid, and a following LW at the same address returns the old contents.
- reqValid held high continuously with alternating SW/LW → exactly one accept per IDLE cycle and correct data on every response.
